// File: rtl/apb4_ps2_rx.sv
// APB4 PS/2 device-to-host receiver: synchronised and glitch-filtered PS/2 inputs,
// an 11-bit frame deframer with parity, stop and timeout checks, and a byte FIFO.
module apb4_ps2_rx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // APB decode
  logic       access, wr_en, rd_en;
  logic [1:0] addr;
  assign access  = psel & penable;
  assign wr_en   = access & pwrite;
  assign rd_en   = access & ~pwrite;
  assign addr    = paddr[3:2];
  assign pready  = 1'b1;
  assign pslverr = 1'b0;

  logic unused_apb;
  assign unused_apb = ^{paddr[31:4], paddr[1:0], pwdata[31:16], pwdata[7:5]};

  logic en_q, irq_en_q;
  logic [7:0] thresh_q;
  logic flush;
  logic [2:0] w1c;
  assign flush = wr_en & (addr == 2'd0) & pwdata[2];
  assign w1c   = (wr_en && addr == 2'd2) ? pwdata[4:2] : 3'b000;

  // Input synchronisers and clock glitch filter
  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_s, dat_s;
  logic       fclk_q, fclk_d, fall_q, fall_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fclk_d = fclk_q;
    fcnt_d = '0;
    fall_d = 1'b0;
    if (clk_s != fclk_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        fclk_d = clk_s;
        fall_d = fclk_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      // NOTE: synchronisers reset to the idle-high bus level so reset release is not seen as a fall.
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      fclk_q     <= 1'b1;
      fcnt_q     <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      fclk_q     <= fclk_d;
      fcnt_q     <= fcnt_d;
      fall_q     <= fall_d;
    end
  end

  // Frame receiver
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          push, perr_set, ferr_set;

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    push     = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (!en_q || flush) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end else if (fall_q) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!dat_s) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end
        end
        S_DATA: begin
          shift_d = {dat_s, shift_q[7:1]};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!dat_s)                   ferr_set = 1'b1;
          else if (^{shift_q, par_q})   push     = 1'b1;
          else                          perr_set = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d  = S_IDLE;
        tmo_d    = '0;
        ferr_set = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  // Receive FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          empty, full, pop, do_push, do_pop, ovf_set;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd_en & (addr == 2'd1) & ~empty;
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~flush;
  assign ovf_set = push & full & ~pop & ~flush;
  assign count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      // NOTE: the storage array is reset too, so every flop in the block has a known value after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= shift_q;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Control, sticky status and interrupt
  logic ovf_q, perr_q, ferr_q, irq_d;
  logic [15:0] count_ext, thresh_ext;
  assign count_ext  = 16'(count_q);
  assign thresh_ext = 16'(thresh_q);
  assign irq_d = irq_en_q & ((count_ext > thresh_ext) | ovf_q | perr_q | ferr_q);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_en && addr == 2'd0) begin
        en_q     <= pwdata[0];
        irq_en_q <= pwdata[1];
        thresh_q <= pwdata[15:8];
      end
      // A set event in the same cycle as a W1C keeps the flag set.
      ovf_q  <= (ovf_q  & ~w1c[0]) | ovf_set;
      perr_q <= (perr_q & ~w1c[1]) | perr_set;
      ferr_q <= (ferr_q & ~w1c[2]) | ferr_set;
      irq_o  <= irq_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (addr)
        2'd0: begin
          prdata[0]    = en_q;
          prdata[1]    = irq_en_q;
          prdata[15:8] = thresh_q;
        end
        2'd1: if (!empty) prdata[7:0] = mem_q[rd_ptr_q];
        2'd2: begin
          prdata[0]       = empty;
          prdata[1]       = full;
          prdata[2]       = ovf_q;
          prdata[3]       = perr_q;
          prdata[4]       = ferr_q;
          prdata[8 +: CW] = count_q;
        end
        default: prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_ps2_rx.sv
// Self-checking bench for apb4_ps2_rx: directed PS/2 frames plus a randomized phase,
// checked against a frame-level queue model of the receiver and register file.
module tb_apb4_ps2_rx;

  localparam int DEPTH = 8;
  localparam int HALF  = 200;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic [31:0] paddr = '0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        irq_o;

  apb4_ps2_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(2000)) dut (
    .hclk(hclk), .hresetn(hresetn), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat), .irq_o(irq_o)
  );

  always #5 hclk = ~hclk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: the FIFO is a plain queue, flags are plain bits.
  logic [7:0] m_q[$];
  bit m_en, m_irqen, m_ovf, m_perr, m_ferr;
  int m_thresh;

  int cyc = 0;
  int chg_cyc = 0;
  bit busy = 1'b1;
  bit exp_valid = 1'b0;
  logic [31:0] exp_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic irq_exp();
    return m_irqen && ((m_q.size() > m_thresh) || m_ovf || m_perr || m_ferr);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      4'h0: r = (m_thresh << 8) | (32'(m_irqen) << 1) | 32'(m_en);
      4'h4: if (m_q.size() != 0) r = 32'(m_q[0]);
      4'h8: r = (m_q.size() << 8) | (32'(m_ferr) << 4) | (32'(m_perr) << 3) |
                (32'(m_ovf) << 2) | (32'(m_q.size() == DEPTH) << 1) | 32'(m_q.size() == 0);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Compare process: read data on every read access, irq_o on every settled cycle.
  always @(negedge hclk) begin
    cyc++;
    if (exp_valid && psel && penable && !pwrite) check("prdata", prdata, exp_rd);
    if (hresetn && !busy && cyc > chg_cyc + 2) check("irq_o", {31'b0, irq_o}, {31'b0, irq_exp()});
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {28'h0, a}; pwdata = d;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    if (a == 4'h0) begin
      m_en = d[0]; m_irqen = d[1]; m_thresh = int'(d[15:8]);
      if (d[2]) m_q.delete();
    end else if (a == 4'h8) begin
      if (d[2]) m_ovf = 1'b0;
      if (d[3]) m_perr = 1'b0;
      if (d[4]) m_ferr = 1'b0;
    end
    chg_cyc = cyc;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    exp_rd = model_read(a);
    exp_valid = 1'b1;
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {28'h0, a};
    @(posedge hclk); #1;
    penable = 1'b1;
    @(negedge hclk);
    d = prdata;
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
    exp_valid = 1'b0;
    if (a == 4'h4 && m_q.size() != 0) void'(m_q.pop_front());
    chg_cyc = cyc;
  endtask

  // Drives the first n bits (start bit first) of an 11-bit frame.
  task automatic send_raw(input logic [10:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      wait_cyc(half);
      ps2_clk = 1'b0;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
    busy = 1'b1;
    send_raw(frame_bits(b, bad_par, bad_stop), 11, half);
    wait_cyc(half);
    if (m_en) begin
      if (bad_stop)                m_ferr = 1'b1;
      else if (bad_par)            m_perr = 1'b1;
      else if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else                         m_q.push_back(b);
    end
    chg_cyc = cyc;
    busy = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_en = 0; m_irqen = 0; m_ovf = 0; m_perr = 0; m_ferr = 0; m_thresh = 0;
  endtask

  logic [31:0] rd;

  initial begin
    model_reset();
    wait_cyc(5);
    hresetn = 1'b1;
    wait_cyc(2);
    chg_cyc = cyc;
    busy = 1'b0;

    // Reset state
    apb_read(4'h8, rd); check("reset_stat", rd, 32'h1);
    apb_read(4'h0, rd); check("reset_ctrl", rd, 32'h0);
    apb_read(4'h4, rd); check("reset_data", rd, 32'h0);
    apb_read(4'hC, rd); check("reserved", rd, 32'h0);
    check("reset_irq", {31'b0, irq_o}, 32'h0);

    // Basic receive
    apb_write(4'h0, 32'h1);
    send_frame(8'h1C, 0, 0, HALF);
    apb_read(4'h8, rd); check("basic_stat", rd, 32'h100);
    apb_read(4'h4, rd); check("basic_data", rd, 32'h1C);
    apb_read(4'h8, rd); check("basic_empty", rd, 32'h1);
    apb_read(4'h4, rd); check("empty_read", rd, 32'h0);

    // Parity error and interrupt
    apb_write(4'h0, 32'h3);
    send_frame(8'h1C, 1, 0, HALF);
    apb_read(4'h8, rd); check("perr_stat", rd, 32'h9);
    wait_cyc(3); check("perr_irq", {31'b0, irq_o}, 32'h1);
    apb_write(4'h8, 32'h08);
    wait_cyc(3); check("perr_clr_irq", {31'b0, irq_o}, 32'h0);
    apb_read(4'h8, rd); check("perr_clr", rd, 32'h1);

    // Overflow and ordering
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 80);
    apb_read(4'h8, rd); check("ovf_stat", rd, 32'h806);
    for (int i = 1; i <= 8; i++) begin
      apb_read(4'h4, rd); check("ovf_order", rd, 32'(i));
    end
    apb_read(4'h8, rd); check("ovf_drained", rd, 32'h5);
    apb_write(4'h8, 32'h04);

    // Timeout and recovery
    busy = 1'b1;
    send_raw(frame_bits(8'hA5, 0, 0), 5, HALF);
    wait_cyc(2100);
    m_ferr = 1'b1;
    chg_cyc = cyc;
    busy = 1'b0;
    apb_read(4'h8, rd); check("tmo_stat", rd, 32'h11);
    apb_write(4'h8, 32'h10);
    send_frame(8'hF0, 0, 0, HALF);
    apb_read(4'h4, rd); check("tmo_recover", rd, 32'hF0);

    // Glitch rejection
    busy = 1'b1;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(50);
    busy = 1'b0;
    send_frame(8'h5A, 0, 0, HALF);
    apb_read(4'h4, rd); check("glitch_data", rd, 32'h5A);

    // Threshold interrupt and flush
    apb_write(4'h0, 32'h103);
    send_frame(8'h11, 0, 0, 80);
    send_frame(8'h22, 0, 0, 80);
    wait_cyc(3); check("thresh_irq", {31'b0, irq_o}, 32'h1);
    apb_write(4'h0, 32'h107);
    wait_cyc(3); check("flush_irq", {31'b0, irq_o}, 32'h0);
    apb_read(4'h8, rd); check("flush_stat", rd, 32'h1);

    // Randomized frames, reads, W1C writes and flushes against the model
    apb_write(4'h0, 32'h1 | (32'($urandom_range(1, 0)) << 1) | (32'($urandom_range(3, 0)) << 8));
    for (int n = 0; n < 14; n++) begin
      int kind;
      kind = int'($urandom_range(9, 0));
      send_frame(8'($urandom), kind == 8, kind == 9, 60);
      for (int r = 0; r < int'($urandom_range(2, 0)); r++) apb_read(4'h4, rd);
      apb_read(4'h8, rd);
      if ($urandom_range(3, 0) == 0) apb_write(4'h8, 32'($urandom_range(7, 0)) << 2);
      if ($urandom_range(7, 0) == 0)
        apb_write(4'h0, 32'h1 | (32'($urandom_range(1, 0)) << 1) | (32'($urandom_range(1, 0)) << 2) |
                        (32'($urandom_range(3, 0)) << 8));
    end
    apb_read(4'h0, rd);

    // Reset in the middle of a frame
    busy = 1'b1;
    send_raw(frame_bits(8'h3C, 0, 0), 4, 60);
    ps2_clk = 1'b0;
    wait_cyc(30);
    hresetn = 1'b0;
    model_reset();
    wait_cyc(3);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    hresetn = 1'b1;
    wait_cyc(3);
    chg_cyc = cyc;
    busy = 1'b0;
    apb_read(4'h8, rd); check("midreset_stat", rd, 32'h1);
    apb_read(4'h0, rd); check("midreset_ctrl", rd, 32'h0);
    check("midreset_irq", {31'b0, irq_o}, 32'h0);

    wait_cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
